// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EX/MEM and MEM/WB register sets, word-addressed data memory,
// register-file write-back ports, EX/MEM forwarding tap, and sticky fault/halt flags.
module mem_wb_stage #(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_instr,
  input  logic [31:0] ex_result,
  input  logic [15:0] ex_store_data,
  input  logic        ex_reg_write,
  input  logic        ex_write_op2,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_halt,
  output logic        wb_we1,
  output logic [3:0]  wb_waddr1,
  output logic [15:0] wb_wdata1,
  output logic        wb_we2,
  output logic [3:0]  wb_waddr2,
  output logic [15:0] wb_wdata2,
  output logic        fwd_mem_valid,
  output logic [3:0]  fwd_mem_reg,
  output logic [15:0] fwd_mem_data,
  output logic        mem_fault,
  output logic        halted
);
  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [15:0] r_dmem [DMEM_WORDS];

  logic        r_halt_seen;
  logic        r_em_valid;
  logic [3:0]  r_em_rd1;
  logic [3:0]  r_em_rd2;
  logic [31:0] r_em_result;
  logic [15:0] r_em_store_data;
  logic        r_em_reg_write;
  logic        r_em_write_op2;
  logic        r_em_mem_read;
  logic        r_em_mem_write;
  logic        r_em_halt;

  logic        r_mw_valid;
  logic        r_mw_we1;
  logic [3:0]  r_mw_waddr1;
  logic [15:0] r_mw_wdata1;
  logic        r_mw_we2;
  logic [3:0]  r_mw_waddr2;
  logic [15:0] r_mw_wdata2;
  logic        r_mem_fault;
  logic        r_halted;

  logic          w_xfer;
  logic [AW-1:0] w_idx;
  logic          w_misaligned;
  logic          w_store;
  logic          w_load;
  logic [15:0]   w_load_data;
  logic          w_we1;
  logic          w_we2;
  logic          w_unused_instr;

  assign w_unused_instr = ^{ex_instr[15:12], ex_instr[3:0]};

  assign ex_ready     = !r_halt_seen;
  assign w_xfer       = ex_valid && !r_halt_seen;
  assign w_idx        = r_em_result[AW:1];
  assign w_misaligned = r_em_result[0] && (r_em_mem_read || r_em_mem_write);
  // Read+write together is a store; halt markers never touch memory or registers.
  assign w_store      = r_em_valid && !r_em_halt && r_em_mem_write && !w_misaligned;
  assign w_load       = r_em_mem_read && !r_em_mem_write;
  assign w_load_data  = w_misaligned ? 16'h0000 : r_dmem[w_idx];
  assign w_we1        = r_em_valid && !r_em_halt && r_em_reg_write;
  assign w_we2        = w_we1 && r_em_write_op2 && !r_em_mem_read && (r_em_rd2 != r_em_rd1);

  assign fwd_mem_valid = r_em_valid && r_em_reg_write && !r_em_mem_read;
  assign fwd_mem_reg   = r_em_rd1;
  assign fwd_mem_data  = r_em_result[15:0];

  assign wb_we1    = r_mw_valid && r_mw_we1;
  assign wb_waddr1 = r_mw_waddr1;
  assign wb_wdata1 = r_mw_wdata1;
  assign wb_we2    = r_mw_valid && r_mw_we2;
  assign wb_waddr2 = r_mw_waddr2;
  assign wb_wdata2 = r_mw_wdata2;
  assign mem_fault = r_mem_fault;
  assign halted    = r_halted;

  // Memory contents survive reset; only the write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && w_store) begin
      r_dmem[w_idx] <= r_em_store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_halt_seen     <= 1'b0;
      r_em_valid      <= 1'b0;
      r_em_rd1        <= 4'h0;
      r_em_rd2        <= 4'h0;
      r_em_result     <= 32'h0;
      r_em_store_data <= 16'h0;
      r_em_reg_write  <= 1'b0;
      r_em_write_op2  <= 1'b0;
      r_em_mem_read   <= 1'b0;
      r_em_mem_write  <= 1'b0;
      r_em_halt       <= 1'b0;
      r_mw_valid      <= 1'b0;
      r_mw_we1        <= 1'b0;
      r_mw_waddr1     <= 4'h0;
      r_mw_wdata1     <= 16'h0;
      r_mw_we2        <= 1'b0;
      r_mw_waddr2     <= 4'h0;
      r_mw_wdata2     <= 16'h0;
      r_mem_fault     <= 1'b0;
      r_halted        <= 1'b0;
    end else begin
      r_em_valid <= w_xfer;
      if (w_xfer) begin
        r_em_rd1        <= ex_instr[11:8];
        r_em_rd2        <= ex_instr[7:4];
        r_em_result     <= ex_result;
        r_em_store_data <= ex_store_data;
        r_em_reg_write  <= ex_reg_write;
        r_em_write_op2  <= ex_write_op2;
        r_em_mem_read   <= ex_mem_read;
        r_em_mem_write  <= ex_mem_write;
        r_em_halt       <= ex_halt;
        if (ex_halt) begin
          r_halt_seen <= 1'b1;
        end
      end

      r_mw_valid  <= r_em_valid;
      r_mw_we1    <= w_we1;
      r_mw_waddr1 <= w_we1 ? r_em_rd1 : 4'h0;
      r_mw_wdata1 <= !w_we1 ? 16'h0 : (w_load ? w_load_data : r_em_result[15:0]);
      r_mw_we2    <= w_we2;
      r_mw_waddr2 <= w_we2 ? r_em_rd2 : 4'h0;
      r_mw_wdata2 <= w_we2 ? r_em_result[31:16] : 16'h0;

      if (r_em_valid && !r_em_halt && w_misaligned) begin
        r_mem_fault <= 1'b1;
      end
      if (r_em_valid && r_em_halt) begin
        r_halted <= 1'b1;
      end
    end
  end
endmodule
